// File: rtl/dma_controller_pkg.sv
// ---------------------------------------------------------------------------
// dma_controller_pkg
// Shared definitions for the DMA engine: default widths and timing, the FSM
// state encoding and a small width helper for counters.
// Imported by dma_controller and dma_controller_word_timer. The CPU side can
// import it for the command width.
// Optional feature macro used by the engine: DMA_CYCLE_STEAL_EN.
// ---------------------------------------------------------------------------
package dma_controller_pkg;

  localparam int unsigned DMA_WORD_SIZE     = 16;
  localparam int unsigned DMA_WRITE_LATENCY = 2;
  localparam int unsigned DMA_BURST_LEN     = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_XFER = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } dma_state_e;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_controller_word_timer.sv
// ---------------------------------------------------------------------------
// dma_controller_word_timer
// Counts the WRITE_LATENCY cycles of one memory write. While paused (bus
// grant lost) the count is held at zero so the word restarts in full once
// the grant returns.
// Ports:
//   clk      in  rising-edge clock
//   reset_n  in  synchronous active-low reset
//   run_i    in  engine is in its transfer state
//   pause_i  in  bus grant currently missing
//   first_o  out current cycle is the first cycle of a word
//   done_o   out current cycle completes the word
// ---------------------------------------------------------------------------
module dma_controller_word_timer
  import dma_controller_pkg::*;
#(
  parameter int unsigned WRITE_LATENCY = DMA_WRITE_LATENCY
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run_i,
  input  logic pause_i,
  output logic first_o,
  output logic done_o
);

  localparam int unsigned CW = cnt_width(WRITE_LATENCY);
  localparam logic [CW-1:0] LAST = CW'(WRITE_LATENCY - 1);

  if (WRITE_LATENCY < 1) begin : g_bad_latency
    $error("WRITE_LATENCY must be >= 1");
  end

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!run_i || pause_i) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign first_o = (count_q == '0);
  assign done_o  = run_i & ~pause_i & (count_q == LAST);

endmodule

// File: rtl/dma_controller.sv
// ---------------------------------------------------------------------------
// dma_controller
// Bus-master DMA engine. Takes a (dest address, word count) command, requests
// the data-memory bus with BR/BG, copies words from the external device
// buffer into memory and pulses dma_done when finished.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (see below)
//   cmd_addr, cmd_len    first destination address, number of words
//   BR / BG              bus request out / bus grant in
//   ed_index / ed_data   device buffer word offset out / word in (comb)
//   dma_writeM           memory write strobe
//   dma_address/dma_data memory address / write data (zero when not writing)
//   dma_done             one-cycle completion interrupt
//   dbg_state_o          current FSM state, for observation only
// Handshake: a command is taken on any rising edge where cmd_valid and
// cmd_ready are both 1; cmd_ready is 1 only while idle, so commands offered
// while busy are dropped, not queued.
// Optional feature: DMA_CYCLE_STEAL_EN releases the bus for one cycle after
// every BURST_LEN words and re-requests it.
// ---------------------------------------------------------------------------
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter int unsigned WORD_SIZE     = DMA_WORD_SIZE,
  parameter int unsigned WRITE_LATENCY = DMA_WRITE_LATENCY,
  parameter int unsigned BURST_LEN     = DMA_BURST_LEN
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  input  logic [WORD_SIZE-1:0] cmd_len,
  output logic                 cmd_ready,
  output logic                 BR,
  input  logic                 BG,
  output logic [WORD_SIZE-1:0] ed_index,
  input  logic [WORD_SIZE-1:0] ed_data,
  output logic                 dma_writeM,
  output logic [WORD_SIZE-1:0] dma_address,
  output logic [WORD_SIZE-1:0] dma_data,
  output logic                 dma_done,
  output logic [2:0]           dbg_state_o
);

  if (BURST_LEN < 1) begin : g_bad_burst
    $error("BURST_LEN must be >= 1");
  end

  dma_state_e           state_q, state_d;
  logic [WORD_SIZE-1:0] base_q, base_d;
  logic [WORD_SIZE-1:0] len_q, len_d;
  logic [WORD_SIZE-1:0] index_q, index_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
`ifdef DMA_CYCLE_STEAL_EN
  logic [WORD_SIZE-1:0] burst_q, burst_d;
`endif

  logic xfer_run;
  logic writing;
  logic word_first;
  logic word_done;
  logic last_word;

  assign xfer_run  = (state_q == ST_XFER);
  // Losing the grant mid-transfer kills the strobe in the same cycle.
  assign writing   = xfer_run & BG;
  assign last_word = (index_q == len_q - 1'b1);

  dma_controller_word_timer #(
    .WRITE_LATENCY (WRITE_LATENCY)
  ) u_word_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .run_i   (xfer_run),
    .pause_i (~BG),
    .first_o (word_first),
    .done_o  (word_done)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    index_d     = index_q;
    data_d      = data_q;
`ifdef DMA_CYCLE_STEAL_EN
    burst_d     = burst_q;
`endif
    cmd_ready   = 1'b0;
    BR          = 1'b0;
    dma_writeM  = 1'b0;
    dma_address = '0;
    dma_data    = '0;
    dma_done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        index_d   = '0;
        if (cmd_valid) begin
          base_d  = cmd_addr;
          len_d   = cmd_len;
`ifdef DMA_CYCLE_STEAL_EN
          burst_d = '0;
`endif
          state_d = (cmd_len == '0) ? ST_DONE : ST_REQ;
        end
      end

      ST_REQ: begin
        BR = 1'b1;
        if (BG) begin
          state_d = ST_XFER;
        end
      end

      ST_XFER: begin
        BR          = 1'b1;
        dma_writeM  = writing;
        if (writing) begin
          // Address wraps naturally at 2^WORD_SIZE.
          dma_address = base_q + index_q;
          // On the first cycle of a word the device word is passed straight
          // through and captured; later cycles replay the captured copy.
          dma_data    = word_first ? ed_data : data_q;
          if (word_first) begin
            data_d = ed_data;
          end
        end
        if (word_done) begin
          if (last_word) begin
            index_d = '0;
            state_d = ST_DONE;
          end else begin
            index_d = index_q + 1'b1;
`ifdef DMA_CYCLE_STEAL_EN
            if (burst_q == WORD_SIZE'(BURST_LEN - 1)) begin
              burst_d = '0;
              state_d = ST_GAP;
            end else begin
              burst_d = burst_q + 1'b1;
            end
`endif
          end
        end
      end

      // One cycle with BR low so the CPU can take the bus back.
      ST_GAP: begin
        state_d = ST_REQ;
      end

      ST_DONE: begin
        dma_done = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      index_q <= '0;
      data_q  <= '0;
`ifdef DMA_CYCLE_STEAL_EN
      burst_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      index_q <= index_d;
      data_q  <= data_d;
`ifdef DMA_CYCLE_STEAL_EN
      burst_q <= burst_d;
`endif
    end
  end

  assign ed_index    = index_q;
  assign dbg_state_o = state_q;

endmodule
